// File: rtl/bit_count_unit.sv
// Multicycle bit-counting unit: population count, leading-zero and trailing-zero
// count, scanning the operand one CHUNK_WIDTH slice per enabled cycle.
module bit_count_unit #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int CHUNK_WIDTH = 4,
    localparam int RES_W       = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic [1:0]            mode_i,
    input  logic                  data_valid_i,
    output logic                  data_valid_o,
    output logic                  idle_o,
    output logic [RES_W-1:0]      result_o
);

    localparam int N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    localparam logic [1:0] MODE_CLZ = 2'b01;
    localparam logic [1:0] MODE_CTZ = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t                  state_q,  state_d;
    logic [DATA_WIDTH-1:0]   shreg_q,  shreg_d;
    logic [1:0]              mode_q,   mode_d;
    logic [RES_W-1:0]        acc_q,    acc_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [RES_W-1:0]        result_q, result_d;
    logic                    valid_q,  valid_d;

    logic [CHUNK_WIDTH-1:0]  low_chunk;
    logic [CHUNK_WIDTH-1:0]  high_chunk;
    logic [RES_W-1:0]        sum;
    logic                    last_chunk;
    logic                    done;

    function automatic logic [RES_W-1:0] chunk_pop(input logic [CHUNK_WIDTH-1:0] c);
        logic [RES_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            n = n + RES_W'(c[i]);
        end
        return n;
    endfunction

    // Only called on a non-zero chunk; the last match in each loop wins.
    function automatic logic [RES_W-1:0] chunk_tz(input logic [CHUNK_WIDTH-1:0] c);
        logic [RES_W-1:0] n;
        n = '0;
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (c[i]) n = RES_W'(i);
        end
        return n;
    endfunction

    function automatic logic [RES_W-1:0] chunk_lz(input logic [CHUNK_WIDTH-1:0] c);
        logic [RES_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (c[i]) n = RES_W'(CHUNK_WIDTH - 1 - i);
        end
        return n;
    endfunction

    assign low_chunk  = shreg_q[CHUNK_WIDTH-1:0];
    assign high_chunk = shreg_q[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign last_chunk = (cnt_q == CNT_W'(N_CHUNKS - 1));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        sum      = acc_q;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_valid_i) begin
                    shreg_d = operand_i;
                    mode_d  = mode_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_COUNT;
                end
            end
            default: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mode_q == MODE_CLZ) begin
                    if (high_chunk == '0) begin
                        sum     = acc_q + RES_W'(CHUNK_WIDTH);
                        shreg_d = shreg_q << CHUNK_WIDTH;
                        done    = last_chunk;
                    end else begin
                        sum  = acc_q + chunk_lz(high_chunk);
                        done = 1'b1;
                    end
                end else if (mode_q == MODE_CTZ) begin
                    if (low_chunk == '0) begin
                        sum     = acc_q + RES_W'(CHUNK_WIDTH);
                        shreg_d = shreg_q >> CHUNK_WIDTH;
                        done    = last_chunk;
                    end else begin
                        sum  = acc_q + chunk_tz(low_chunk);
                        done = 1'b1;
                    end
                end else begin
                    // Reserved mode 2'b11 falls through to population count.
                    sum     = acc_q + chunk_pop(low_chunk);
                    shreg_d = shreg_q >> CHUNK_WIDTH;
                    done    = last_chunk;
                end
                acc_d = sum;
                if (done) begin
                    result_d = sum;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            mode_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign idle_o       = (state_q == S_IDLE);
    assign data_valid_o = valid_q;
    assign result_o     = result_q;

endmodule

// File: tb/tb_bit_count_unit.sv
// Bench for bit_count_unit: four instances (chunk widths 4, 1, 32, 8) share one
// stimulus stream and are checked every cycle against a whole-word latency/result model.
module tb_bit_count_unit;

    localparam int NI = 4;

    function automatic int cw_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 32;
            default: return 8;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] operand;
    logic [1:0]  mode;
    logic        dvalid;

    logic        idle_w  [NI];
    logic        valid_w [NI];
    logic [5:0]  res_w   [NI];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        bit_count_unit #(
            .DATA_WIDTH (32),
            .CHUNK_WIDTH(cw_of(gi))
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .clk_en_i    (en),
            .operand_i   (operand),
            .mode_i      (mode),
            .data_valid_i(dvalid),
            .data_valid_o(valid_w[gi]),
            .idle_o      (idle_w[gi]),
            .result_o    (res_w[gi])
        );
    end

    // Whole-word reference: result from the operand as a whole.
    function automatic int ref_res(input logic [31:0] op, input logic [1:0] m);
        int n;
        n = 0;
        if (m == 2'b01) begin
            for (int i = 31; i >= 0; i--) begin
                if (op[i]) break;
                n++;
            end
        end else if (m == 2'b10) begin
            for (int i = 0; i < 32; i++) begin
                if (op[i]) break;
                n++;
            end
        end else begin
            n = $countones(op);
        end
        return n;
    endfunction

    function automatic int ref_lat(input logic [31:0] op, input logic [1:0] m, input int cw);
        int nch;
        nch = 32 / cw;
        if ((m == 2'b01 || m == 2'b10) && op != 32'd0) return ref_res(op, m) / cw + 1;
        return nch;
    endfunction

    // Model: cycles remaining until completion, pending and visible results.
    int         rem     [NI];
    logic [5:0] pend    [NI];
    logic [5:0] exp_res [NI];
    bit         exp_val [NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                rem[k]     <= 0;
                exp_res[k] <= '0;
                exp_val[k] <= 1'b0;
            end else if (en) begin
                exp_val[k] <= 1'b0;
                if (rem[k] > 1) begin
                    rem[k] <= rem[k] - 1;
                end else if (rem[k] == 1) begin
                    rem[k]     <= 0;
                    exp_val[k] <= 1'b1;
                    exp_res[k] <= pend[k];
                end else if (dvalid) begin
                    rem[k]  <= ref_lat(operand, mode, cw_of(k));
                    pend[k] <= 6'(ref_res(operand, mode));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (idle_w[k] !== (rem[k] == 0) || valid_w[k] !== exp_val[k] ||
                    res_w[k] !== exp_res[k]) begin
                    n_fail++;
                    if (n_fail < 40)
                        $display("FAIL cycle inst%0d cw=%0d: idle=%b valid=%b result=%0d, required idle=%b valid=%b result=%0d at %0t",
                                 k, cw_of(k), idle_w[k], valid_w[k], res_w[k],
                                 (rem[k] == 0), exp_val[k], exp_res[k], $time);
                end
            end
        end
    end

    task automatic wait_all_idle();
        int t;
        bit all;
        en = 1'b1;
        for (t = 0; t < 200; t++) begin
            all = 1'b1;
            for (int k = 0; k < NI; k++) if (!idle_w[k]) all = 1'b0;
            if (all) break;
            @(negedge clk);
        end
        if (t == 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: instances still busy after 200 cycles, required idle");
        end
    endtask

    task automatic issue(input logic [31:0] op, input logic [1:0] m);
        operand = op;
        mode    = m;
        dvalid  = 1'b1;
        @(negedge clk);
        dvalid  = 1'b0;
    endtask

    // Counts edges from the accept edge until instance k shows its valid pulse.
    task automatic wait_valid(input int k, input int start, output int lat);
        lat = start;
        while (!valid_w[k] && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_txn(input string name, input int k, input int lat,
                             input int exp_r, input int exp_l);
        n_cmp++;
        if (!valid_w[k] || res_w[k] !== 6'(exp_r) || lat != exp_l) begin
            n_fail++;
            $display("FAIL %s: valid=%b result=%0d latency=%0d, required result=%0d latency=%0d",
                     name, valid_w[k], res_w[k], lat, exp_r, exp_l);
        end else begin
            $display("txn %s: result=%0d latency=%0d", name, res_w[k], lat);
        end
    endtask

    task automatic directed(input string name, input int k, input logic [31:0] op,
                            input logic [1:0] m, input int exp_r, input int exp_l);
        int lat;
        wait_all_idle();
        issue(op, m);
        wait_valid(k, 0, lat);
        check_txn(name, k, lat, exp_r, exp_l);
    endtask

    task automatic pin_model(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: model gives %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        int lat;
        logic [31:0] op;
        logic [1:0]  m;

        rst = 1'b1; en = 1'b1; operand = '0; mode = '0; dvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        n_cmp++;
        if (res_w[0] !== 6'd0 || idle_w[0] !== 1'b1 || valid_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: result=%0d idle=%b valid=%b, required 0 1 0",
                     res_w[0], idle_w[0], valid_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;

        pin_model("model_clz", ref_res(32'h0001_0000, 2'b01), 15);
        pin_model("model_ctz_lat", ref_lat(32'h0000_0080, 2'b10, 4), 2);
        pin_model("model_zero_lat", ref_lat(32'h0, 2'b01, 4), 8);

        directed("cpop_ones",   0, 32'hFFFF_FFFF, 2'b00, 32, 8);
        directed("cpop_zero",   0, 32'h0000_0000, 2'b00, 0, 8);
        directed("clz_bit16",   0, 32'h0001_0000, 2'b01, 15, 4);
        directed("clz_msb",     0, 32'h8000_0000, 2'b01, 0, 1);
        directed("clz_zero",    0, 32'h0000_0000, 2'b01, 32, 8);
        directed("ctz_bit7",    0, 32'h0000_0080, 2'b10, 7, 2);
        directed("ctz_bit0",    0, 32'h0000_0001, 2'b10, 0, 1);
        directed("reserved",    0, 32'h0000_00F0, 2'b11, 4, 8);
        directed("sweep_cw1",   1, 32'hA5A5_A5A5, 2'b00, 16, 32);
        directed("sweep_cw32",  2, 32'hA5A5_A5A5, 2'b00, 16, 1);
        directed("sweep_cw8",   3, 32'h00FF_0000, 2'b01, 8, 2);

        // Back-to-back: second request presented in the valid cycle.
        wait_all_idle();
        issue(32'h0000_000F, 2'b00);
        wait_valid(0, 0, lat);
        check_txn("b2b_first", 0, lat, 4, 8);
        issue(32'h0000_0100, 2'b10);
        wait_valid(0, 0, lat);
        check_txn("b2b_second", 0, lat, 8, 3);

        // Request and mode changes during COUNT are ignored.
        wait_all_idle();
        issue(32'h0000_000F, 2'b00);
        operand = 32'hFFFF_FFFF; mode = 2'b01; dvalid = 1'b1;
        repeat (3) @(negedge clk);
        dvalid = 1'b0;
        wait_valid(0, 3, lat);
        check_txn("ignore_busy", 0, lat, 4, 8);

        // Clock-enable stall of three cycles mid-CPOP.
        wait_all_idle();
        issue(32'h1234_5678, 2'b00);
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_valid(0, 5, lat);
        check_txn("stall", 0, lat, 13, 11);

        // Reset during COUNT aborts the operation.
        wait_all_idle();
        issue(32'hFFFF_FFFF, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (res_w[0] !== 6'd0 || idle_w[0] !== 1'b1 || valid_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: result=%0d idle=%b valid=%b, required 0 1 0",
                     res_w[0], idle_w[0], valid_w[0]);
        end else begin
            $display("txn abort: result=%0d idle=%b", res_w[0], idle_w[0]);
        end
        repeat (10) @(negedge clk);
        directed("after_reset", 0, 32'h0000_0300, 2'b10, 8, 3);

        // Random traffic with random enable gaps; requests may hit busy instances.
        for (int n = 0; n < 200; n++) begin
            op = $urandom() >> $urandom_range(0, 32);
            if ($urandom_range(0, 1) == 1) op = op << $urandom_range(0, 31);
            m = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 12)) begin
                en = ($urandom_range(0, 7) != 0);
                @(negedge clk);
            end
            en = 1'b1;
            $display("txn rand%0d: op=%h mode=%0d", n, op, m);
            issue(op, m);
        end
        wait_all_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
